// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_arbiter_pkg
//   Shared constants for the adder-sharing arbiter slice.
//   A_W/B_W/SUM_W : operand and result widths of the shared adder.
//   B_PAD         : zero bits prepended to B so it lines up with A.
//   STAT_W        : width of each statistics counter
//                   (used when ADDER_SHARE_ARBITER_STATS_EN is defined).
package adder_share_arbiter_pkg;

   localparam int A_W    = 63;
   localparam int B_W    = 59;
   localparam int SUM_W  = A_W + 1;
   localparam int B_PAD  = A_W - B_W;
   localparam int STAT_W = 16;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
//   Bundles the requester, shared-adder and response signals of the
//   adder-sharing arbiter.
//   req_valid/req_ready/req_a/req_b : NUM_REQ request channels (packed).
//   add_a/add_b/add_sum             : operands to, and sum from, the
//                                     external shared adder.
//   rsp_valid/rsp_ready/rsp_id/rsp_sum : single tagged response channel.
//   Modports: master = requesters/adder/consumer side, slave = arbiter.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where valid and ready are both high; valid, once raised
// by a producer that has no alternative path, and its payload stay put
// until that transfer; ready may depend combinationally on valid.
interface adder_share_arbiter_if
   import adder_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic [A_W-1:0]         add_a;
   logic [B_W-1:0]         add_b;
   logic [SUM_W-1:0]       add_sum;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [SUM_W-1:0]       rsp_sum;

   modport master (
      output req_valid, req_a, req_b, add_sum, rsp_ready,
      input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
   );

   modport slave (
      input  req_valid, req_a, req_b, add_sum, rsp_ready,
      output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
   );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// adder_share_arbiter_rr_arbiter
//   Purely combinational round-robin picker.
//   req    : request vector.
//   ptr    : highest-priority index this cycle; search runs ptr, ptr+1, ...
//            with wrap.
//   en     : when low, grant is forced to zero (winner still reported).
//   grant  : one-hot grant or zero.
//   winner : index of the first requester found from ptr.
//   The pointer update lives in the parent so it only moves on a handshake.
module adder_share_arbiter_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    winner
);

   logic found;

   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      grant  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(ptr) + off) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
      if (en && found) begin
         grant[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Time-multiplexes one external 64-bit adder (A 63b + zero-extended B 59b)
//   between NUM_REQ requesters. Round-robin grant, operand register stage
//   (OP) feeding the adder, result register stage (RSP) with valid/ready
//   backpressure. Request at cycle T returns at T+2 when unstalled; one
//   result per cycle when saturated.
//   Ports:
//     clk, rst_n  : rising-edge clock, asynchronous active-low reset.
//     bus (slave) : requester channels, adder operands/sum, response channel.
//     busy        : OP or RSP stage holds an operation.
//   Optional (macro ADDER_SHARE_ARBITER_STATS_EN):
//     stat_clr    : synchronous clear of the counters, wins over increment.
//     stat_grants : NUM_REQ x 16-bit saturating grant counters.
//     stat_stall  : 16-bit saturating count of cycles with a request
//                   pending but no requester accepted.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   adder_share_arbiter_if.slave      bus,
`ifdef ADDER_SHARE_ARBITER_STATS_EN
   input  logic                      stat_clr,
   output logic [NUM_REQ*STAT_W-1:0] stat_grants,
   output logic [STAT_W-1:0]         stat_stall,
`endif
   output logic                      busy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // OP stage
   logic                op_vld;
   logic [A_W-1:0]      op_a;
   logic [B_W-1:0]      op_b;
   logic [ID_W-1:0]     op_id;

   // RSP stage
   logic                rsp_vld;
   logic [ID_W-1:0]     rsp_id_q;
   logic [SUM_W-1:0]    rsp_sum_q;

   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     nxt_ptr;
   logic [ID_W-1:0]     winner;
   logic [NUM_REQ-1:0]  grant;
   logic                adv;
   logic                can_issue;
   logic                hs;
   logic [A_W-1:0]      sel_a;
   logic [B_W-1:0]      sel_b;

   // OP moves into RSP when RSP is empty or being drained this cycle.
   assign adv       = op_vld & (~rsp_vld | bus.rsp_ready);
   assign can_issue = ~op_vld | adv;

   // rst_n gates the grant so req_ready reads zero while held in reset.
   adder_share_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req    (bus.req_valid),
      .ptr    (rr_ptr),
      .en     (can_issue & rst_n),
      .grant  (grant),
      .winner (winner)
   );

   assign bus.req_ready = grant;
   assign hs            = |grant;

   // One-hot AND-OR operand mux.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = sel_a | bus.req_a[i*A_W +: A_W];
            sel_b = sel_b | bus.req_b[i*B_W +: B_W];
         end
      end
   end

   always_comb begin
      nxt_ptr = '0;
      if (winner != ID_W'(NUM_REQ - 1)) begin
         nxt_ptr = winner + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_vld <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         op_id  <= '0;
         rr_ptr <= '0;
      end else begin
         if (hs) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= winner;
            op_vld <= 1'b1;
            rr_ptr <= nxt_ptr;
         end else if (adv) begin
            op_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld   <= 1'b0;
         rsp_id_q  <= '0;
         rsp_sum_q <= '0;
      end else begin
         if (adv) begin
            rsp_sum_q <= bus.add_sum;
            rsp_id_q  <= op_id;
            rsp_vld   <= 1'b1;
         end else if (rsp_vld && bus.rsp_ready) begin
            rsp_vld <= 1'b0;
         end
      end
   end

   // The adder sees registered operands only.
   assign bus.add_a     = op_a;
   assign bus.add_b     = op_b;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign busy          = op_vld | rsp_vld;

`ifdef ADDER_SHARE_ARBITER_STATS_EN
   logic [NUM_REQ*STAT_W-1:0] grants_q;
   logic [STAT_W-1:0]         stall_q;
   logic                      stall_now;

   assign stall_now = (|bus.req_valid) & ~hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grants_q <= '0;
         stall_q  <= '0;
      end else if (stat_clr) begin
         grants_q <= '0;
         stall_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               grants_q[i*STAT_W +: STAT_W] <= sat_inc(grants_q[i*STAT_W +: STAT_W]);
            end
         end
         if (stall_now) begin
            stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign stat_grants = grants_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//   Directed bench for adder_share_arbiter with NUM_REQ=4. Models the
//   external adder, drives requesters and the response consumer, and checks
//   every observation against hand-computed constants.
//   Optional section runs when ADDER_SHARE_ARBITER_STATS_EN is defined.
module tb_adder_share_arbiter;
   import adder_share_arbiter_pkg::*;

   localparam int NREQ = 4;

   logic clk;
   logic rst_n;
   logic busy;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
   logic                   stat_clr;
   logic [NREQ*STAT_W-1:0] stat_grants;
   logic [STAT_W-1:0]      stat_stall;
`endif

   int vecs;
   int errs;

   adder_share_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   adder_share_arbiter #(
      .NUM_REQ (NREQ)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
`ifdef ADDER_SHARE_ARBITER_STATS_EN
      .stat_clr    (stat_clr),
      .stat_grants (stat_grants),
      .stat_stall  (stat_stall),
`endif
      .busy        (busy)
   );

   // External shared adder.
   assign bus.add_sum = {1'b0, bus.add_a} + {{(B_PAD + 1){1'b0}}, bus.add_b};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
      bus.req_a[i*A_W +: A_W] = a;
      bus.req_b[i*B_W +: B_W] = b;
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [63:0] exp_sum [NREQ];
   logic [3:0]  exp_rdy;
   int          g;

   initial begin
      vecs = 0;
      errs = 0;
      exp_sum[0] = 64'h0000_0000_0000_0003;
      exp_sum[1] = 64'h0000_0000_0000_0030;
      exp_sum[2] = 64'h87FF_FFFF_FFFF_FFFE;
      exp_sum[3] = 64'h0000_0001_2345_678A;

      // ---- reset ----
      rst_n         = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
      stat_clr      = 1'b0;
`endif
      #12;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id",    bus.rsp_id,    0);
      chk("rst_rsp_sum",   bus.rsp_sum,   0);
      chk("rst_add_a",     bus.add_a,     0);
      chk("rst_add_b",     bus.add_b,     0);
      chk("rst_busy",      busy,          0);
      bus.req_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- single request, carry into bit 63 ----
      set_req(0, 63'h7FFF_FFFF_FFFF_FFFF, 59'h1);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b1;
      #1;
      chk("t1_req_ready", bus.req_ready, 4'b0001);
      chk("t1_rsp_valid_T", bus.rsp_valid, 0);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("t1_add_a", bus.add_a, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("t1_add_b", bus.add_b, 64'h1);
      chk("t1_busy", busy, 1);
      chk("t1_rsp_valid_T1", bus.rsp_valid, 0);
      tick();
      #1;
      chk("t1_rsp_valid_T2", bus.rsp_valid, 1);
      chk("t1_rsp_sum", bus.rsp_sum, 64'h8000_0000_0000_0000);
      chk("t1_rsp_id", bus.rsp_id, 0);
      tick();
      #1;
      chk("t1_rsp_drained", bus.rsp_valid, 0);
      chk("t1_idle", busy, 0);

      // ---- saturated: all four valid, pointer starts at 1 ----
      set_req(0, 63'h1, 59'h2);
      set_req(1, 63'h10, 59'h20);
      set_req(2, 63'h7FFF_FFFF_FFFF_FFFF, 59'h7FF_FFFF_FFFF_FFFF);
      set_req(3, 63'h1_2345_6789, 59'h1);
      bus.req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) bus.req_valid = 4'h0;
         #1;
         exp_rdy = (c < 8) ? 4'(1 << ((1 + c) % 4)) : 4'h0;
         chk("sat_req_ready", bus.req_ready, exp_rdy);
         if (c >= 2) begin
            g = (c - 1) % 4;
            chk("sat_rsp_valid", bus.rsp_valid, 1);
            chk("sat_rsp_id", bus.rsp_id, g);
            chk("sat_rsp_sum", bus.rsp_sum, exp_sum[g]);
         end else begin
            chk("sat_rsp_valid_early", bus.rsp_valid, 0);
         end
         tick();
      end
      #1;
      chk("sat_drained", bus.rsp_valid, 0);
      tick();

      // ---- backpressure: req1 then req2 accepted, 5 stalled cycles ----
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0010;
      #1;
      chk("bp_rdy_first", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = 4'b0100;
      #1;
      chk("bp_rdy_second", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = 4'b1000;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_hold_valid", bus.rsp_valid, 1);
         chk("bp_hold_id", bus.rsp_id, 1);
         chk("bp_hold_sum", bus.rsp_sum, exp_sum[1]);
         chk("bp_hold_ready_zero", bus.req_ready, 0);
         chk("bp_hold_busy", busy, 1);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_rel_id1", bus.rsp_id, 1);
      chk("bp_rel_valid1", bus.rsp_valid, 1);
      chk("bp_rel_grant3", bus.req_ready, 4'b1000);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("bp_rel_valid2", bus.rsp_valid, 1);
      chk("bp_rel_id2", bus.rsp_id, 2);
      chk("bp_rel_sum2", bus.rsp_sum, exp_sum[2]);
      tick();
      #1;
      chk("bp_rel_valid3", bus.rsp_valid, 1);
      chk("bp_rel_id3", bus.rsp_id, 3);
      chk("bp_rel_sum3", bus.rsp_sum, exp_sum[3]);
      tick();
      #1;
      chk("bp_drained", bus.rsp_valid, 0);
      tick();

      // ---- wrap and skip: move pointer to 3, then req1+req3 ----
      bus.req_valid = 4'b0100;
      #1;
      chk("ws_rdy_req2", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = 4'b1010;
      #1;
      chk("ws_rdy_req3", bus.req_ready, 4'b1000);
      tick();
      #1;
      chk("ws_rdy_req1", bus.req_ready, 4'b0010);
      chk("ws_rsp_id2", bus.rsp_id, 2);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("ws_rsp_id3", bus.rsp_id, 3);
      chk("ws_rsp_sum3", bus.rsp_sum, exp_sum[3]);
      tick();
      #1;
      chk("ws_rsp_id1", bus.rsp_id, 1);
      chk("ws_rsp_sum1", bus.rsp_sum, exp_sum[1]);
      // Pointer should now be 2: with req1 and req3 valid, req3 wins.
      bus.req_valid = 4'b1010;
      #1;
      chk("ws_ptr_probe", bus.req_ready, 4'b1000);
      bus.req_valid = 4'b0000;
      #1;
      chk("ws_withdraw", bus.req_ready, 0);
      tick();
      #1;
      chk("ws_drained", bus.rsp_valid, 0);
      tick();

      // ---- async reset with OP and RSP full ----
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      #1;
      chk("ar_rdy_req0", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = 4'b0010;
      #1;
      chk("ar_rdy_req1", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("ar_full_valid", bus.rsp_valid, 1);
      chk("ar_full_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_rsp_valid", bus.rsp_valid, 0);
      chk("ar_rsp_sum", bus.rsp_sum, 0);
      chk("ar_rsp_id", bus.rsp_id, 0);
      chk("ar_add_a", bus.add_a, 0);
      chk("ar_add_b", bus.add_b, 0);
      chk("ar_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.rsp_ready = 1'b1;
      set_req(3, 63'h5, 59'h7);
      bus.req_valid = 4'b1000;
      #1;
      chk("ar_new_rdy", bus.req_ready, 4'b1000);
      chk("ar_new_T", bus.rsp_valid, 0);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("ar_new_T1", bus.rsp_valid, 0);
      tick();
      #1;
      chk("ar_new_T2_valid", bus.rsp_valid, 1);
      chk("ar_new_T2_id", bus.rsp_id, 3);
      chk("ar_new_T2_sum", bus.rsp_sum, 64'hC);
      tick();
      #1;
      chk("ar_new_drained", bus.rsp_valid, 0);
      tick();

`ifdef ADDER_SHARE_ARBITER_STATS_EN
      // ---- statistics counters ----
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      chk("st_clr_grants", stat_grants, 0);
      chk("st_clr_stall", stat_stall, 0);
      bus.req_valid = 4'b0100;
      tick();
      tick();
      tick();
      bus.req_valid = 4'b0000;
      tick();
      tick();
      tick();
      #1;
      chk("st_grants2_3", stat_grants[2*STAT_W +: STAT_W], 3);
      chk("st_stall_0", stat_stall, 0);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0100;
      for (int k = 0; k < 6; k++) tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("st_grants2_5", stat_grants[2*STAT_W +: STAT_W], 5);
      chk("st_stall_4", stat_stall, 4);
      chk("st_grants0", stat_grants[0 +: STAT_W], 0);
      // Clear while a stall is still in progress: clear must win.
      bus.req_valid = 4'b0100;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      chk("st_clr_prio_stall", stat_stall, 0);
      chk("st_clr_prio_grants", stat_grants, 0);
      for (int k = 0; k < 65540; k++) tick();
      #1;
      chk("st_stall_sat", stat_stall, 16'hFFFF);
      bus.req_valid = 4'b0000;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Time-multiplexes one shared 63+59-bit unsigned adder datapath between NUM_REQ independent requesters.
- The adder zero-extends B by 4 bits and produces a 64-bit sum. Requesters are, for example, partial-product accumulation stages of the multiplier.
- Round-robin arbitration selects the requester; operands are registered into the shared adder, and the sum is returned on a single tagged response channel with valid/ready backpressure.
- The adder itself is external; this block drives its operands and samples its sum.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 63, operand A width.
- B_W, 59, operand B width (zero-extended to A_W).
- SUM_W, 64, result width (A_W+1).
- ID_W, 2, requester-id width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  packed A operands; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed B operands.
- add_a  out  A_W  operand A to the shared adder.
- add_b  out  B_W  operand B to the shared adder.
- add_sum  in  SUM_W  combinational sum from the shared adder.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  ID_W  requester index of the result.
- rsp_sum  out  SUM_W  registered sum.
- busy  out  1  high while the operand or result stage is occupied.

Behaviour:
- Reset is asynchronous, active-low. Clock is clk.
  - On rst_n low: op_vld=0, rsp_valid=0, rsp_id=0, rsp_sum=0, add_a=0, add_b=0, rr_ptr=0, req_ready=0, busy=0.
  - Reset mid-operation discards all in-flight operations; no response is produced for them.
- Two-stage pipeline:
  - OP stage: registers op_a, op_b, op_id and op_vld. add_a=op_a and add_b=op_b come straight from registers, never from req_* combinationally.
  - RSP stage: registers rsp_sum, rsp_id and rsp_valid.
- Flow control:
  - adv = op_vld & (~rsp_valid | rsp_ready). When adv is high, RSP loads add_sum and op_id, and rsp_valid is set.
  - rsp_valid clears on rsp_valid & rsp_ready & ~adv.
  - can_issue = ~op_vld | adv.
  - grant = round-robin winner among req_valid, searching from rr_ptr upward with wrap.
  - req_ready[i] = can_issue & grant[i]. This is combinational from req_valid, rr_ptr and state. req_ready is never high for a requester whose req_valid is low.
  - On handshake: op_* loads the granted operands, op_vld is set, and rr_ptr = winner+1 mod NUM_REQ.
  - When no request is present, rr_ptr holds; if adv is high, op_vld clears.
- Latency and throughput:
  - Request handshake at cycle T gives rsp_valid at T+2 when there is no backpressure.
  - Throughput is 1 result per cycle when requesters are saturated.
- Backpressure:
  - rsp_valid high with rsp_ready low: RSP holds and op holds. Once op is full, req_ready is 0 for all requesters.
  - rsp_sum and rsp_id are stable while rsp_valid & ~rsp_ready.
- Arithmetic: sum = A + {4'b0, B}, unsigned, 64 bits. Bit 63 is the carry. The block does no arithmetic itself.
- Simultaneous events:
  - Same-cycle RSP drain, OP advance and new grant are legal; all three occur together.
  - A requester deasserting req_valid without a handshake loses nothing.
- busy = op_vld | rsp_valid.

Optional Feature:
- Macro: ADDER_SHARE_ARBITER_STATS_EN.
- When defined, the block adds the following outputs, all reset to 0:
  - stat_grants: NUM_REQ*16, per-requester saturating grant counters.
  - stat_stall: 16, saturating count of cycles where any req_valid is high and req_ready is all-zero.
- It also adds the input stat_clr (synchronous clear, takes priority over increment).
- When the macro is undefined, these ports and counters are absent; functionality and timing are otherwise identical.

Decomposition:
- Shared package (header) holds:
  - width constants A_W=63, B_W=59, SUM_W=64 and B_PAD=A_W-B_W=4;
  - the stats counter width, 16.
- Natural sub-module: rr_arbiter (req vector, ptr, en) -> one-hot grant and winner index, purely combinational, with rr_ptr update kept in the parent.

Test Plan:
- Single request: req0 A=63'h7FFF_FFFF_FFFF_FFFF, B=1 at T → req_ready[0]=1 at T; rsp_valid at T+2 with rsp_sum=64'h8000_0000_0000_0000 and rsp_id=0.
- All four requesters valid continuously with rsp_ready=1 → grants 0,1,2,3,0,… one per cycle; rsp_id sequence matches; each sum equals A+B.
- Backpressure: two requests accepted, then rsp_ready=0 for 5 cycles → rsp_sum and rsp_id stable, req_ready all 0, no loss. Release → both results delivered in order on consecutive cycles.
- Wrap and skip: rr_ptr=3, only req1 and req3 valid → req3 granted, then req1. rr_ptr ends at 2.
- Async reset: assert rst_n=0 mid-cycle with op and rsp full → outputs go to zero immediately without a clock. After release, the first new request returns its correct result with latency 2.
- STATS_EN: 3 grants to req2 and 4 stall cycles → stat_grants[2]=3 and stat_stall=4. stat_clr zeroes both; counters saturate at 16'hFFFF.
